spi_tx_shifter: RTL
===================

Name: spi_tx_shifter

Overview:
Downstream consumer of the clock-divider output. Takes a parallel word over a valid/ready handshake and shifts it out MSB-first on a mode-0 serial interface (sclk idle low; mosi changes on falling edge, sampled by slave on rising edge). Uses the divider's output only as a timing reference: it is registered and edge-detected in the clk domain, never used as a clock. One bit is sent per div_clk period.

Parameters:
DATA_W, 16, width of transmitted word (≥2)
CNT_W, $clog2(DATA_W), width of bit counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
div_clk  in  1  divided clock from divider stage; free-running; period ≥4 clk, high/low phases ≥2 clk each
tx_data  in  DATA_W  word to send; sampled only on accept
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a word
sclk  out  1  serial clock to slave
mosi  out  1  serial data, MSB first
cs_n  out  1  slave select, active-low
busy  out  1  high in any state other than IDLE
done  out  1  single-cycle pulse when frame ends (same cycle cs_n returns high)

Behaviour:
- Reset (rst high at posedge clk): state=IDLE, sclk=0, mosi=0, cs_n=1, tx_ready=1, busy=0, done=0, shift register=0, bit counter=0, div_q=0. Reset mid-frame aborts immediately; no partial-frame completion, no done pulse.
- Edge detect: div_q <= div_clk each cycle. rise = div_clk & ~div_q; fall = ~div_clk & div_q. rise and fall are mutually exclusive by construction. All outputs are registered.
- Accept: tx_valid & tx_ready at posedge → shreg<=tx_data, bitcnt<=DATA_W-1, state<=SETUP, tx_ready<=0, busy<=1. tx_valid without tx_ready is ignored; tx_data may change freely afterwards.
- IDLE: cs_n=1, sclk=0, tx_ready=1. Edge events ignored.
- SETUP: cs_n<=0 on entry cycle; mosi<=shreg[DATA_W-1]. Wait for next fall → state SHIFT. Guarantees ≥ one low phase of mosi setup before first sclk rise.
- SHIFT:
  - on rise: sclk<=1.
  - on fall: sclk<=0; if bitcnt==0 → state HOLD; else shreg<=shreg<<1, mosi<=shreg[DATA_W-2], bitcnt<=bitcnt-1.
  - exactly DATA_W sclk rising edges per frame; mosi stable across each rise.
- HOLD: sclk=0, cs_n=0, mosi unchanged. On next fall: cs_n<=1, mosi<=0, done<=1 (one cycle), busy<=0, tx_ready<=1, state<=IDLE.
- Back-to-back: a new word may be accepted the cycle after done; it enters SETUP, so cs_n high for ≥1 clk between frames.
- Frame length: cs_n low from accept+1 to end = (DATA_W+1) div periods plus 0..1 period SETUP phase alignment.
- div_clk stuck (no edges): block waits indefinitely in current state; only rst recovers.
- Bit counter arithmetic unsigned, never wraps (transition at 0 exits SHIFT).

Test Plan:
- Reset values: hold rst 3 cycles with tx_valid=1 → tx_ready=1, cs_n=1, sclk=0, mosi=0, busy=0, done=0; no accept during reset.
- Single frame: DATA_W=8, div_clk period 16 clk (8 high/8 low), send 0xA5 → mosi at 8 sclk rises = 1,0,1,0,0,1,0,1; exactly 8 sclk rises; one done pulse; cs_n low 9–10 div periods.
- Handshake: tx_valid held high with changing tx_data during busy → only first word transmitted, tx_ready=0 until done cycle+1; second word 0x3C then sent correctly back-to-back, cs_n high ≥1 clk between frames.
- Edge words: send 0x00 and 0xFF → mosi constant 0 / 1 at all 8 rises; send 0x80 → only first rise samples 1.
- Reset mid-frame: assert rst after 4th sclk rise of 0xA5 → next cycle cs_n=1, sclk=0, no done; following frame 0x5A transmits correctly.
- Min-period div_clk (2 high/2 low): 16-bit 0xBEEF → correct MSB-first bits, 16 rises, mosi stable at each rise.

Source files
------------

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - mode-0 SPI word transmitter timed by an edge-detected divider clock
module spi_tx_shifter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clk,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state, state_d;
  logic              div_q;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [CNT_W-1:0]  bitcnt, bitcnt_d;
  logic              tx_ready_d, sclk_d, mosi_d, cs_n_d, busy_d, done_d;
  logic              rise, fall, accept;

  // div_clk is only a timing reference; edges are found against its registered copy
  assign rise   = div_clk & ~div_q;
  assign fall   = ~div_clk & div_q;
  assign accept = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_q    <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      tx_ready <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      div_q    <= div_clk;
      shreg    <= shreg_d;
      bitcnt   <= bitcnt_d;
      tx_ready <= tx_ready_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (fall) state_d = SHIFT;
      SHIFT:   if (fall && bitcnt == '0) state_d = HOLD;
      HOLD:    if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d    = shreg;
    bitcnt_d   = bitcnt;
    tx_ready_d = tx_ready;
    sclk_d     = sclk;
    mosi_d     = mosi;
    cs_n_d     = cs_n;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        sclk_d     = 1'b0;
        cs_n_d     = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        // First bit is presented together with cs_n so it has a full low phase of setup
        if (accept) begin
          shreg_d    = tx_data;
          bitcnt_d   = CNT_W'(DATA_W - 1);
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          cs_n_d     = 1'b0;
          mosi_d     = tx_data[DATA_W-1];
        end
      end
      SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = shreg[DATA_W-1];
      end
      SHIFT: begin
        if (rise) begin
          sclk_d = 1'b1;
        end else if (fall) begin
          sclk_d = 1'b0;
          if (bitcnt != '0) begin
            shreg_d  = shreg << 1;
            mosi_d   = shreg[DATA_W-2];
            bitcnt_d = bitcnt - CNT_W'(1);
          end
        end
      end
      HOLD: begin
        sclk_d = 1'b0;
        if (fall) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
